emg_sample_framer: RTL and testbench

Capture stage directly downstream of the EMG digital stimulus generator. It watches that generator's ADC clock, start strobe and channel-select outputs and shifts in the serial result returned by the EMG SAR ADC. Each completed conversion becomes a channel-tagged, frame-marked word in a small FWFT FIFO, which the readout/telemetry logic drains over a valid/ready port.

---
 rtl/emg_sample_framer.sv | 161 ++++++++++++++++
 tb/tb_emg_sample_framer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emg_sample_framer.sv
// Captures serial EMG SAR ADC conversions into channel-tagged, frame-marked words
// and buffers them in a first-word-fall-through FIFO drained over valid/ready.
module emg_sample_framer #(
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          ADC_CLK_EMG,
  input  logic                          START_EMG,
  input  logic [3:0]                    CH_SEL_EMG,
  input  logic                          DOUT_EMG,
  input  logic                          CLR_FLAGS,
  output logic [ADC_BITS+4:0]           DATA_OUT,
  output logic                          VALID,
  input  logic                          READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW,
  output logic                          SYNC_ERR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(ADC_BITS);
  localparam int unsigned WW = ADC_BITS + 5;
  localparam logic [CW-1:0] LastBit = CW'(ADC_BITS - 1);
  localparam logic [4:0]    NumCh   = 5'(NUM_CH);

  typedef enum logic [1:0] {StIdle, StConv, StPush} state_e;

  state_e                r_state;
  logic                  r_adc_clk_q;
  logic [3:0]            r_ch;
  logic [ADC_BITS-1:0]   r_shreg;
  logic [CW-1:0]         r_bit_cnt;
  logic [WW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_valid;
  logic [WW-1:0]         r_data_out;
  logic                  r_overflow;
  logic                  r_sync_err;

  logic                  w_edge;
  logic                  w_ch_ok;
  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_sync_set;
  logic [WW-1:0]         w_push_word;
  logic [WW-1:0]         w_head_d;
  logic [AW:0]           w_wr_ptr_d;
  logic [AW:0]           w_rd_ptr_d;
  logic [AW:0]           w_count_d;

  assign w_edge      = ADC_CLK_EMG & ~r_adc_clk_q;
  assign w_ch_ok     = {1'b0, CH_SEL_EMG} < NumCh;
  assign w_push_req  = (r_state == StPush) && ENABLE;
  assign w_pop       = r_valid && READY;
  assign w_full      = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_push_word = {(r_ch == 4'd0), r_ch, r_shreg};
  assign w_sync_set  = ENABLE && w_edge && START_EMG &&
                       (((r_state == StIdle) && !w_ch_ok) || (r_state == StConv));

  assign w_wr_ptr_d  = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_d  = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_count_d   = w_wr_ptr_d - w_rd_ptr_d;

  // The incoming word becomes the head only when it lands in the slot the head will point at.
  always_comb begin
    w_head_d = r_mem[w_rd_ptr_d[AW-1:0]];
    if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_d[AW-1:0])) begin
      w_head_d = w_push_word;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_adc_clk_q <= 1'b0;
    end else begin
      r_adc_clk_q <= ADC_CLK_EMG;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_ch      <= 4'd0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (!ENABLE) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_edge && START_EMG && w_ch_ok) begin
            r_state   <= StConv;
            r_ch      <= CH_SEL_EMG;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
          end
        end
        StConv: begin
          if (w_edge) begin
            r_shreg   <= {r_shreg[ADC_BITS-2:0], DOUT_EMG};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LastBit) begin
              r_state <= StPush;
            end
          end
        end
        StPush:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_valid    <= (w_count_d != '0);
      r_data_out <= w_head_d;
    end
  end

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_overflow <= w_drop     || (r_overflow && !CLR_FLAGS);
      r_sync_err <= w_sync_set || (r_sync_err && !CLR_FLAGS);
    end
  end

  assign DATA_OUT   = r_data_out;
  assign VALID      = r_valid;
  assign FIFO_COUNT = r_wr_ptr - r_rd_ptr;
  assign OVERFLOW   = r_overflow;
  assign SYNC_ERR   = r_sync_err;

endmodule

// File: tb/tb_emg_sample_framer.sv
// Bench for emg_sample_framer: scoreboard of expected words plus directed corner cases.
module tb_emg_sample_framer;

  localparam int ADC_BITS = 12;
  localparam int W        = ADC_BITS + 5;

  logic         CLK = 1'b0;
  logic         RESET, ENABLE, ADC_CLK_EMG, START_EMG, DOUT_EMG, CLR_FLAGS, READY;
  logic [3:0]   CH_SEL_EMG;
  logic [W-1:0] DATA_OUT, DATA_OUT12;
  logic         VALID, VALID12, OVERFLOW, OVERFLOW12, SYNC_ERR, SYNC_ERR12;
  logic [3:0]   FIFO_COUNT, FIFO_COUNT12;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   ch;
    logic [11:0]  data;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[16];

  emg_sample_framer u_dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ADC_CLK_EMG(ADC_CLK_EMG),
    .START_EMG(START_EMG), .CH_SEL_EMG(CH_SEL_EMG), .DOUT_EMG(DOUT_EMG),
    .CLR_FLAGS(CLR_FLAGS), .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY),
    .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW), .SYNC_ERR(SYNC_ERR)
  );

  emg_sample_framer #(.NUM_CH(12)) u_dut12 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ADC_CLK_EMG(ADC_CLK_EMG),
    .START_EMG(START_EMG), .CH_SEL_EMG(CH_SEL_EMG), .DOUT_EMG(DOUT_EMG),
    .CLR_FLAGS(CLR_FLAGS), .DATA_OUT(DATA_OUT12), .VALID(VALID12), .READY(READY),
    .FIFO_COUNT(FIFO_COUNT12), .OVERFLOW(OVERFLOW12), .SYNC_ERR(SYNC_ERR12)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One ADC clock period: 2 CLK high, 2 CLK low; optional READY pulse in the PUSH cycle.
  task automatic adc_edge(input logic st, input logic [3:0] ch, input logic d,
                          input logic rdy_pulse);
    ADC_CLK_EMG = 1'b1; START_EMG = st; CH_SEL_EMG = ch; DOUT_EMG = d;
    step();
    if (rdy_pulse) READY = 1'b1;
    step();
    if (rdy_pulse) READY = 1'b0;
    ADC_CLK_EMG = 1'b0; START_EMG = 1'b0;
    step();
    step();
  endtask

  task automatic convert(input logic [3:0] ch, input logic [11:0] data, input int mid_idx,
                         input logic rdy_last);
    adc_edge(1'b1, ch, 1'b0, 1'b0);
    for (int i = 0; i < ADC_BITS; i++) begin
      adc_edge(i == mid_idx, ch, data[ADC_BITS-1-i], rdy_last && (i == ADC_BITS - 1));
    end
  endtask

  task automatic pulse_clr();
    CLR_FLAGS = 1'b1;
    step();
    CLR_FLAGS = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    READY = 1'b1;
    while ((exp_q.size() != 0 || VALID) && k < 300) begin
      step();
      k++;
    end
    chk(name, 32'(k < 300), 32'd1);
    repeat (20) step();
    READY = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (!RESET && VALID && READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h required none", DATA_OUT);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard_word", 32'(DATA_OUT), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d;
    for (int i = 0; i < 16; i++) begin
      tbl[i].ch   = 4'(i);
      tbl[i].data = 12'((i * 12'h13B) ^ 12'h5A0);
      tbl[i].exp  = {(i == 0), 4'(i), tbl[i].data};
    end

    RESET = 1'b1; ENABLE = 1'b0; ADC_CLK_EMG = 1'b0; START_EMG = 1'b0; DOUT_EMG = 1'b0;
    CLR_FLAGS = 1'b0; READY = 1'b0; CH_SEL_EMG = 4'd0;
    #23;
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_data", 32'(DATA_OUT), 32'd0);
    chk("rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_sync", 32'(SYNC_ERR), 32'd0);
    step();
    RESET = 1'b0;
    ENABLE = 1'b1;
    step();

    // Single conversion with exact latency.
    d = 12'hA5C;
    adc_edge(1'b1, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < ADC_BITS - 1; i++) adc_edge(1'b0, 4'd5, d[ADC_BITS-1-i], 1'b0);
    ADC_CLK_EMG = 1'b1; DOUT_EMG = d[0];
    step();
    @(negedge CLK);
    chk("single_valid_early", 32'(VALID), 32'd0);
    step();
    @(negedge CLK);
    chk("single_valid", 32'(VALID), 32'd1);
    chk("single_data", 32'(DATA_OUT), 32'h05A5C);
    chk("single_count", 32'(FIFO_COUNT), 32'd1);
    ADC_CLK_EMG = 1'b0;
    step();
    step();
    exp_q.push_back(17'h05A5C);
    drain("single_drain");

    // Full frame sweep from the vector table.
    pulse_clr();
    READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(tbl[i].exp);
      convert(tbl[i].ch, tbl[i].data, -1, 1'b0);
    end
    drain("sweep_drain");
    chk("sweep_ovf", 32'(OVERFLOW), 32'd0);
    chk("sweep_sync", 32'(SYNC_ERR), 32'd0);

    // Overflow: ninth word dropped.
    pulse_clr();
    READY = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({(i == 0), 4'(i), 12'(12'h100 + i)});
      convert(4'(i), 12'(12'h100 + i), -1, 1'b0);
    end
    chk("ovf_count", 32'(FIFO_COUNT), 32'd8);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    drain("ovf_drain");
    chk("ovf_count_empty", 32'(FIFO_COUNT), 32'd0);
    pulse_clr();
    chk("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // Full FIFO with a pop in the PUSH cycle.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, 4'(i + 1), 12'(12'h200 + i)});
      convert(4'(i + 1), 12'(12'h200 + i), -1, 1'b0);
    end
    chk("full_count", 32'(FIFO_COUNT), 32'd8);
    exp_q.push_back({1'b0, 4'd9, 12'hBEE});
    convert(4'd9, 12'hBEE, -1, 1'b1);
    chk("fullpop_count", 32'(FIFO_COUNT), 32'd8);
    chk("fullpop_ovf", 32'(OVERFLOW), 32'd0);
    drain("fullpop_drain");

    // START during the 6th data edge: flag set, word still produced.
    pulse_clr();
    exp_q.push_back({1'b0, 4'd3, 12'h3C9});
    convert(4'd3, 12'h3C9, 5, 1'b0);
    chk("midstart_sync", 32'(SYNC_ERR), 32'd1);
    drain("midstart_drain");

    // Channel 15 is out of range only for the 12-channel instance.
    pulse_clr();
    exp_q.push_back({1'b0, 4'd15, 12'h7E1});
    convert(4'd15, 12'h7E1, -1, 1'b0);
    chk("badch_sync12", 32'(SYNC_ERR12), 32'd1);
    chk("badch_count12", 32'(FIFO_COUNT12), 32'd0);
    chk("badch_sync16", 32'(SYNC_ERR), 32'd0);
    chk("badch_count16", 32'(FIFO_COUNT), 32'd1);
    drain("badch_drain");

    // ENABLE dropped mid-conversion: no word, next conversion normal.
    pulse_clr();
    adc_edge(1'b1, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) adc_edge(1'b0, 4'd2, 1'b1, 1'b0);
    ENABLE = 1'b0;
    repeat (3) step();
    ENABLE = 1'b1;
    repeat (40) step();
    chk("abort_count", 32'(FIFO_COUNT), 32'd0);
    chk("abort_valid", 32'(VALID), 32'd0);
    exp_q.push_back({1'b0, 4'd7, 12'h0F7});
    convert(4'd7, 12'h0F7, -1, 1'b0);
    chk("abort_next_count", 32'(FIFO_COUNT), 32'd1);
    drain("abort_drain");

    // Async reset mid-conversion with two words queued and a flag set.
    exp_q.push_back({1'b0, 4'd1, 12'h111});
    convert(4'd1, 12'h111, 2, 1'b0);
    exp_q.push_back({1'b0, 4'd2, 12'h222});
    convert(4'd2, 12'h222, -1, 1'b0);
    chk("prereset_count", 32'(FIFO_COUNT), 32'd2);
    adc_edge(1'b1, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) adc_edge(1'b0, 4'd4, 1'b1, 1'b0);
    ADC_CLK_EMG = 1'b1;
    #3;
    RESET = 1'b1;
    exp_q.delete();
    #1;
    chk("areset_valid", 32'(VALID), 32'd0);
    chk("areset_data", 32'(DATA_OUT), 32'd0);
    chk("areset_count", 32'(FIFO_COUNT), 32'd0);
    chk("areset_sync", 32'(SYNC_ERR), 32'd0);
    chk("areset_ovf", 32'(OVERFLOW), 32'd0);
    ADC_CLK_EMG = 1'b0;
    step();
    step();
    RESET = 1'b0;
    step();
    exp_q.push_back({1'b1, 4'd0, 12'h5E3});
    convert(4'd0, 12'h5E3, -1, 1'b0);
    chk("postreset_count", 32'(FIFO_COUNT), 32'd1);
    drain("postreset_drain");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
